// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM.
// Round-robin between A and B when idle, optional ownership lock with a
// no-activity timeout, and one-cycle read-valid tracking per requester.
module sp_ram_arbiter #(
    parameter int add_wd  = 4,
    parameter int data_wd = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_rnw,
    input  logic               a_lock,
    input  logic [add_wd-1:0]  a_add,
    input  logic [data_wd-1:0] a_wr_data,
    input  logic               b_req,
    input  logic               b_rnw,
    input  logic               b_lock,
    input  logic [add_wd-1:0]  b_add,
    input  logic [data_wd-1:0] b_wr_data,
    output logic               a_gnt,
    output logic               b_gnt,
    output logic               a_rd_valid,
    output logic               b_rd_valid,
    output logic [data_wd-1:0] rd_data,
    output logic               ram_cs,
    output logic               ram_rnw,
    output logic [add_wd-1:0]  ram_add,
    output logic [data_wd-1:0] ram_wr_data,
    input  logic [data_wd-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t     state;
    logic       last_b;   // 1 = B was granted last, so A wins the next tie
    logic [3:0] tcnt;     // consecutive ownership cycles without a grant

    // Grant decision: combinational from requests and current ownership
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (a_req && b_req) begin
                        a_gnt = last_b;
                        b_gnt = !last_b;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                OWN_A:   a_gnt = a_req;
                OWN_B:   b_gnt = b_req;
                default: ;
            endcase
        end
    end

    // RAM command mux: granted side's fields, or a quiet read-idle pattern
    always_comb begin
        ram_cs      = a_gnt | b_gnt;
        ram_rnw     = 1'b1;
        ram_add     = '0;
        ram_wr_data = '0;
        if (a_gnt) begin
            ram_rnw     = a_rnw;
            ram_add     = a_add;
            ram_wr_data = a_wr_data;
        end else if (b_gnt) begin
            ram_rnw     = b_rnw;
            ram_add     = b_add;
            ram_wr_data = b_wr_data;
        end
    end

    // Read data comes straight from the RAM; validity is tracked separately
    assign rd_data = ram_rd_data;

    // Ownership FSM, round-robin pointer, timeout counter and read-valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            tcnt       <= 4'd0;
            a_rd_valid <= 1'b0;
            b_rd_valid <= 1'b0;
        end else begin
            a_rd_valid <= a_gnt & a_rnw;
            b_rd_valid <= b_gnt & b_rnw;
            if (a_gnt) begin
                last_b <= 1'b0;
                tcnt   <= 4'd0;
                state  <= a_lock ? OWN_A : IDLE;
            end else if (b_gnt) begin
                last_b <= 1'b1;
                tcnt   <= 4'd0;
                state  <= b_lock ? OWN_B : IDLE;
            end else if (state != IDLE) begin
                // The count reaches 15 on the fifteenth idle ownership
                // cycle; ownership is released at that edge.
                if (tcnt == 4'd14) begin
                    state <= IDLE;
                    tcnt  <= 4'd0;
                end else begin
                    tcnt <= tcnt + 4'd1;
                end
            end else begin
                tcnt <= 4'd0;
            end
        end
    end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter add_wd, default 4, RAM address width.
REQ-002 Parameter data_wd, default 32, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a_req / b_req  input  1  requester A / B wants one RAM access this cycle.
REQ-006 a_rnw / b_rnw  input  1  1 = read, 0 = write.
REQ-007 a_lock / b_lock  input  1  requester asks to keep ownership after this access.
REQ-008 a_add / b_add  input  add_wd  access address.
REQ-009 a_wr_data / b_wr_data  input  data_wd  write data.
REQ-010 a_gnt / b_gnt  output  1  access accepted this cycle (combinational from req and state).
REQ-011 a_rd_valid / b_rd_valid  output  1  registered; read data for this requester is on rd_data.
REQ-012 rd_data  output  data_wd  pass-through of ram_rd_data.
REQ-013 ram_cs, ram_rnw  output  1  to the single-port RAM.
REQ-014 ram_add  output  add_wd; ram_wr_data  output  data_wd  to the RAM.
REQ-015 ram_rd_data  input  data_wd  from the RAM, valid the cycle after a read is issued.

Function
REQ-016 States: IDLE, OWN_A, OWN_B; reset state IDLE.
REQ-017 At most one gnt per cycle; ram_cs = a_gnt | b_gnt.
REQ-018 ram_rnw/ram_add/ram_wr_data carry the granted requester's fields in the same cycle; when no grant: ram_cs=0, ram_rnw=1, ram_add=0, ram_wr_data=0.
REQ-019 IDLE, one requester: grant it.
REQ-020 IDLE, both requesting: grant the side not marked by priority pointer last_gnt (reset value: last_gnt=B, so A wins first); after any grant, last_gnt = granted side.
REQ-021 A granted with a_lock=1 -> next state OWN_A; likewise B -> OWN_B; lock=0 -> IDLE.
REQ-022 OWN_A: only A can be granted; b_gnt=0 regardless of b_req; A granted with a_lock=0 -> IDLE; a_req=0 -> remain OWN_A.
REQ-023 OWN_B symmetric to OWN_A.
REQ-024 Ownership timeout: 4-bit counter counts consecutive OWN_x cycles with no grant; at 15 -> IDLE, counter cleared; cleared on any grant or entry to IDLE.
REQ-025 Read latency exactly 1: x_rd_valid asserted the cycle after x_gnt with x_rnw=1, one cycle only; writes never produce rd_valid.
REQ-026 Back-to-back reads (any requester mix) every cycle are supported; rd_valid follows the issuing sequence one cycle later.
REQ-027 Write then read to the same address on consecutive cycles returns the written data (RAM ordering, no bypass in arbiter).
REQ-028 rd_data undefined when neither rd_valid is high; arbiter does not hold or gate it.

Reset
REQ-029 rst high at a posedge: state=IDLE, last_gnt=B, timeout counter=0, a_rd_valid=b_rd_valid=0.
REQ-030 While rst high: a_gnt=b_gnt=0, ram_cs=0; requests ignored.
REQ-031 Reset mid-read: rd_valid for the in-flight read is suppressed (0 the cycle after rst).

Verification
REQ-032 Both req, rnw=1, add A=3 B=5, 4 cycles, no lock -> grants A,B,A,B; rd_valid alternates one cycle later, rd_data = ram[3],ram[5],...
REQ-033 A writes 0xDEADBEEF to 7, next cycle B reads 7 -> b_rd_valid=1 with rd_data=0xDEADBEEF two cycles after the write grant.
REQ-034 A req with a_lock=1 for 3 accesses while b_req held high -> b_gnt=0 throughout; first access after A's final lock=0 grant goes to B.
REQ-035 A locks then drops a_req, b_req high -> b_gnt stays 0 for 15 cycles, state returns to IDLE, B granted the following cycle.
REQ-036 rst asserted the cycle after an A read grant -> a_rd_valid=0 next cycle; after rst, simultaneous requests grant A first.
REQ-037 No requests for 10 cycles -> ram_cs=0, ram_add=0, both rd_valid=0 every cycle.
